// File: rtl/spi_adc_slave_pkg.sv
// Shared definitions for the SPI ADC slave: conversion FSM encoding and frame
// header layout.
package spi_adc_slave_pkg;

    // Conversion request FSM
    typedef enum logic [1:0] {
        C_IDLE = 2'b00,
        C_REQ  = 2'b01,
        C_REL  = 2'b10
    } conv_state_e;

    // Frame header: {VALID, NEW, 2'b00} precedes the WIDTH data bits
    localparam int unsigned HDR_BITS  = 4;
    localparam int unsigned HDR_VALID = 3;
    localparam int unsigned HDR_NEW   = 2;

    // Build the frame header from the result flags
    function automatic logic [HDR_BITS-1:0] make_header(input logic valid,
                                                        input logic fresh);
        logic [HDR_BITS-1:0] hdr;
        hdr            = '0;
        hdr[HDR_VALID] = valid;
        hdr[HDR_NEW]   = fresh;
        return hdr;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser plus edge detector for an asynchronous pin.
// Ports:
//   clk, reset_  system clock, async active-low reset
//   din          asynchronous input pin
//   rise_c       1-cycle pulse: synchronised level went 0 -> 1
//   fall_c       1-cycle pulse: synchronised level went 1 -> 0
// Pulses are combinational from the last sync stage and the edge flop, so a
// registered consumer acts SYNC_STAGES+1 clocks after the pin changes.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Sync chain and edge-detect flop
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_adc_slave.sv
// SPI mode-0 slave front end for adc_controller. Each cs_ fall loads the
// previously captured result into the shift register and starts a new
// conversion (pipelined read). Frame = {VALID, NEW, 2'b00, data}, MSB first.
// Ports:
//   clk, reset_   system clock, async active-low reset
//   sclk, cs_     SPI clock / chip select (async to clk)
//   miso, miso_oe serial data out and pad drive enable
//   adc_en_       conversion request to adc_controller (active low)
//   adc_ack       conversion complete from adc_controller
//   adc_data      conversion result, valid while adc_ack=1
//   busy          conversion request outstanding
module spi_adc_slave
    import spi_adc_slave_pkg::*;
#(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             sclk,
    input  logic             cs_,
    output logic             miso,
    output logic             miso_oe,
    output logic             adc_en_,
    input  logic             adc_ack,
    input  logic [WIDTH-1:0] adc_data,
    output logic             busy
);

    localparam int unsigned FRAME_BITS = WIDTH + HDR_BITS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    logic sclk_rise_c, sclk_fall_c;
    logic cs_rise_c, cs_fall_c;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .reset_ (reset_),
        .din    (sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .reset_ (reset_),
        .din    (cs_),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    conv_state_e state_q, state_d;
    logic        pend_q, pend_d;
    logic        ack_q;
    logic        ack_rise_c;
    logic        capture_c;

    assign ack_rise_c = adc_ack & ~ack_q;

    // State register; adc_en_/busy registered from the next state
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= C_IDLE;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            adc_en_ <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ack_q   <= adc_ack;
            adc_en_ <= (state_d != C_REQ);
            busy    <= (state_d == C_REQ);
        end
    end

    // Next state; a cs_ fall during release is held in pend until ack drops
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        capture_c = 1'b0;
        unique case (state_q)
            C_IDLE: begin
                if (cs_fall_c) state_d = C_REQ;
            end
            C_REQ: begin
                if (ack_rise_c) begin
                    capture_c = 1'b1;
                    state_d   = C_REL;
                end else if (cs_rise_c) begin
                    state_d = C_IDLE;
                end
            end
            C_REL: begin
                // A frame that already ended needs no conversion
                if (cs_fall_c)      pend_d = 1'b1;
                else if (cs_rise_c) pend_d = 1'b0;
                if (!adc_ack) begin
                    state_d = pend_d ? C_REQ : C_IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = C_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result hold, flags and serialiser
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]      hold_q;
    logic                  valid_q, new_q;
    logic [FRAME_BITS-2:0] shreg_q;
    logic [CNT_W-1:0]      count_q;
    logic                  armed_q;
    logic [FRAME_BITS-1:0] frame_word_c;

    assign frame_word_c = {make_header(valid_q, new_q), hold_q};

    // Capture wins over the frame-start NEW clear; the load uses old values
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
        end else if (capture_c) begin
            hold_q  <= adc_data;
            valid_q <= 1'b1;
            new_q   <= 1'b1;
        end else if (cs_fall_c) begin
            new_q   <= 1'b0;
        end
    end

    // MSB is driven straight from the load; shreg holds the remaining bits.
    // A falling edge shifts only after a rising edge inside the frame, so a
    // stray fall right at frame start cannot skip the first bit.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            shreg_q <= '0;
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (cs_fall_c) begin
            shreg_q <= frame_word_c[FRAME_BITS-2:0];
            miso    <= frame_word_c[FRAME_BITS-1];
            miso_oe <= 1'b1;
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (cs_rise_c) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            armed_q <= 1'b0;
        end else if (miso_oe) begin
            if (sclk_rise_c) armed_q <= 1'b1;
            if (sclk_fall_c && armed_q) begin
                armed_q <= 1'b0;
                shreg_q <= {shreg_q[FRAME_BITS-3:0], 1'b0};
                miso    <= (count_q < CNT_W'(FRAME_BITS - 1)) ? shreg_q[FRAME_BITS-2] : 1'b0;
                if (count_q < CNT_W'(FRAME_BITS)) count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Scoreboard bench for spi_adc_slave with a behavioural adc_controller model.
module tb_spi_adc_slave;

    localparam int unsigned WIDTH    = 12;
    localparam int unsigned CONV_LAT = 20;

    logic             clk = 1'b0;
    logic             reset_;
    logic             sclk;
    logic             cs_;
    logic             miso;
    logic             miso_oe;
    logic             adc_en_;
    logic             adc_ack;
    logic [WIDTH-1:0] adc_data;
    logic             busy;

    logic [WIDTH-1:0] vin;
    int               rel_delay;
    bit               glitch;

    always #5 clk = ~clk;

    spi_adc_slave #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .sclk     (sclk),
        .cs_      (cs_),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .adc_en_  (adc_en_),
        .adc_ack  (adc_ack),
        .adc_data (adc_data),
        .busy     (busy)
    );

    typedef struct {
        logic [15:0] word;
        int          pulses;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // adc_controller model: ack CONV_LAT clocks after en_ falls, hold ack
    // until en_ has been high for rel_delay clocks; optional data glitch
    // one clock after ack rises to expose repeated captures
    initial begin : adc_model
        int cnt;
        int phase;
        int held;
        cnt = 0; phase = 0; held = 0;
        adc_ack  = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (reset_ !== 1'b1) begin
                adc_ack = 1'b0;
                cnt = 0; phase = 0;
            end else if (phase == 0) begin
                if (!adc_en_) begin
                    cnt++;
                    if (cnt >= CONV_LAT) begin
                        adc_data = vin;
                        adc_ack  = 1'b1;
                        phase = 1; cnt = 0; held = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                held++;
                if (glitch && held == 1) adc_data = ~vin;
                if (adc_en_) begin
                    cnt++;
                    if (cnt >= rel_delay) begin
                        adc_ack = 1'b0;
                        phase = 0; cnt = 0;
                    end
                end
            end
        end
    end

    // Host-side bit capture: every sclk rise while the pad is driven
    logic [31:0] rx_hist = '0;
    int          total_bits = 0;

    always @(posedge sclk) begin
        if (miso_oe === 1'b1) begin
            rx_hist = {rx_hist[30:0], miso};
            total_bits++;
        end
    end

    // Monitor: at each end of frame pop an expectation and compare
    initial begin : monitor
        logic        oe_prev;
        int          start_bits;
        int          n;
        int          n16;
        logic [31:0] bits;
        logic [31:0] got;
        logic [31:0] want;
        logic [31:0] wide;
        exp_t        e;
        oe_prev = 1'b0;
        start_bits = 0;
        forever begin
            @(negedge clk);
            if (miso_oe === 1'b1 && !oe_prev) begin
                start_bits = total_bits;
            end else if (miso_oe !== 1'b1 && oe_prev) begin
                n = total_bits - start_bits;
                bits = rx_hist & ((32'd1 << n) - 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected bits=%0d word=%0h", n, bits);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", 32'(n), 32'(e.pulses));
                    if (n > 0) begin
                        n16  = (n > 16) ? 16 : n;
                        got  = (n > 16) ? (bits >> (n - 16)) : bits;
                        wide = {16'h0, e.word};
                        want = wide >> (16 - n16);
                        check("frame_word", got, want);
                        if (n > 16)
                            check("frame_tail", bits & ((32'd1 << (n - 16)) - 32'd1), 32'h0);
                    end
                end
            end
            oe_prev = (miso_oe === 1'b1);
        end
    end

    task automatic frame_begin(input logic [15:0] w, input int p);
        exp_t e;
        e.word   = w;
        e.pulses = p;
        exp_q.push_back(e);
        cs_ = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulses(input int p);
        repeat (p) begin
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [15:0] w, input int p);
        frame_begin(w, p);
        pulses(p);
        cs_ = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string name);
        int i;
        i = 0;
        while (adc_ack !== lvl && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(adc_ack), 32'(lvl));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset_ = 1'b0; sclk = 1'b0; cs_ = 1'b1;
        vin = '0; rel_delay = 2; glitch = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'(0));
        check("rst_oe", 32'(miso_oe), 32'(0));
        check("rst_en", 32'(adc_en_), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        reset_ = 1'b1;
        repeat (3) @(negedge clk);

        // First frame after reset reads zero and triggers a conversion
        vin = 12'hA5C;
        fork
            frame(16'h0000, 16);
            begin
                repeat (5) @(negedge clk);
                check("t1_en_low", 32'(adc_en_), 32'(0));
                check("t1_busy", 32'(busy), 32'(1));
                wait_ack(1'b1, 100, "t1_ack");
                repeat (3) @(negedge clk);
                check("t1_en_rel", 32'(adc_en_), 32'(1));
                check("t1_busy_rel", 32'(busy), 32'(0));
            end
        join
        frame(16'hCA5C, 16);

        // Back-to-back pipelined reads
        vin = 12'h123;
        frame(16'hCA5C, 16);
        vin = 12'hFFF;
        frame(16'hC123, 16);
        frame(16'hCFFF, 16);

        // Aborted frame: request withdrawn, hold kept, NEW cleared
        begin
            exp_t e;
            e.word = 16'h0000;
            e.pulses = 0;
            exp_q.push_back(e);
        end
        cs_ = 1'b0;
        repeat (6) @(negedge clk);
        cs_ = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_en", 32'(adc_en_), 32'(1));
        check("t3_busy", 32'(busy), 32'(0));
        repeat (4) @(negedge clk);
        vin = 12'h456;
        frame(16'h8FFF, 16);

        // Over-long frame: trailing bits are zero, pad released promptly
        vin = 12'h777;
        frame_begin(16'hC456, 20);
        pulses(20);
        cs_ = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_oe_off", 32'(miso_oe), 32'(0));
        check("t5_miso_off", 32'(miso), 32'(0));
        repeat (2) @(negedge clk);

        // Reset in the middle of a frame
        vin = 12'h789;
        frame_begin(16'hC777, 5);
        pulses(5);
        #2 reset_ = 1'b0;
        #1;
        check("t4_oe", 32'(miso_oe), 32'(0));
        check("t4_en", 32'(adc_en_), 32'(1));
        check("t4_busy", 32'(busy), 32'(0));
        check("t4_miso", 32'(miso), 32'(0));
        @(negedge clk);
        cs_ = 1'b1;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        repeat (3) @(negedge clk);
        frame(16'h0000, 16);
        vin = 12'h321;
        frame(16'hC789, 16);

        // Long ack: single capture, release held, cs_ fall remembered
        vin = 12'h6AB; rel_delay = 60; glitch = 1'b1;
        frame(16'hC321, 4);
        vin = 12'h5E7;
        fork
            frame(16'hC6AB, 16);
            begin
                repeat (8) @(negedge clk);
                check("t6_ack_held", 32'(adc_ack), 32'(1));
                check("t6_en_rel", 32'(adc_en_), 32'(1));
                check("t6_busy_rel", 32'(busy), 32'(0));
                wait_ack(1'b0, 200, "t6_ack_drop");
                repeat (4) @(negedge clk);
                check("t6_pend_en", 32'(adc_en_), 32'(0));
                check("t6_pend_busy", 32'(busy), 32'(1));
            end
        join
        glitch = 1'b0; rel_delay = 2;
        frame(16'hC5E7, 16);

        repeat (20) @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
